// File: rtl/multi_string_comparator.sv
// Multi-pattern byte-string matcher over a 32-bit word stream, with sticky per-slot flags and delayed forwarding.
// Optional build macro MULTI_STRING_CASE_FOLD_EN folds ASCII upper case to lower case before comparison.
module multi_string_comparator #(
  parameter int NUM_PATTERNS = 4,
  parameter int MAX_LEN      = 17,
  parameter int CNT_W        = 16,
  localparam int SEL_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [31:0]             data_in,
  input  logic                    prog_we,
  input  logic                    prog_len_we,
  input  logic [SEL_W-1:0]        prog_sel,
  input  logic [IDX_W-1:0]        prog_idx,
  input  logic [7:0]              prog_data,
  output logic [NUM_PATTERNS-1:0] match_vec,
  output logic                    match_any,
  output logic [SEL_W-1:0]        match_id,
  output logic [CNT_W-1:0]        first_match_off,
  output logic                    out_valid,
  output logic [31:0]             data_out
);

  localparam int WIN_WORDS = (MAX_LEN + 6) / 4;
  localparam int WIN_BYTES = 4 * WIN_WORDS;
  localparam int FILL_W    = $clog2(WIN_BYTES + 1);
  localparam int BI_W      = $clog2(WIN_BYTES);

  // Window byte 0 is the latest byte ([7:0]) of the newest word; higher indices are older.
  logic [7:0]              win_q [WIN_BYTES];
  logic [FILL_W-1:0]       fill_q;
  logic [7:0]              pat_q [NUM_PATTERNS][MAX_LEN];
  logic [7:0]              len_q [NUM_PATTERNS];
  logic                    acc_q;
  logic [NUM_PATTERNS-1:0] match_vec_q, match_vec_d, hit_vec;
  logic [CNT_W-1:0]        cnt_q, first_q;
  logic                    out_valid_q;
  logic [31:0]             data_out_q;

  function automatic logic [7:0] fold_byte(input logic [7:0] b);
`ifdef MULTI_STRING_CASE_FOLD_EN
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
    return b;
`endif
  endfunction

  // Alignment a ends the pattern on window byte a; char i sits a+len-1-i bytes back.
  always_comb begin
    int         len;
    logic       ok;
    logic [BI_W-1:0] bi;
    hit_vec = '0;
    len     = 0;
    ok      = 1'b0;
    bi      = '0;
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      len = (int'(len_q[p]) > MAX_LEN) ? MAX_LEN : int'(len_q[p]);
      for (int a = 0; a < 4; a++) begin
        ok = (len != 0) && (a + len <= int'(fill_q));
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i < len) begin
            bi = BI_W'(a + len - 1 - i);
            if (fold_byte(pat_q[p][i]) != fold_byte(win_q[bi])) ok = 1'b0;
          end
        end
        hit_vec[p] = hit_vec[p] | ok;
      end
    end
  end

  assign match_vec_d = match_vec_q | (acc_q ? hit_vec : '0);

  always_comb begin
    match_id = '0;
    for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
      if (match_vec_q[p]) match_id = SEL_W'(p);
    end
  end

  // in_valid is a strobe with no back-pressure: every cycle it is high, data_in is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < WIN_BYTES; j++) win_q[j] <= '0;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        len_q[p] <= '0;
        for (int i = 0; i < MAX_LEN; i++) pat_q[p][i] <= '0;
      end
      fill_q      <= '0;
      acc_q       <= 1'b0;
      match_vec_q <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      if (clear) begin
        for (int j = 0; j < WIN_BYTES; j++) win_q[j] <= '0;
        fill_q      <= '0;
        acc_q       <= 1'b0;
        match_vec_q <= '0;
        cnt_q       <= '0;
        first_q     <= '0;
        out_valid_q <= 1'b0;
        data_out_q  <= '0;
      end else begin
        match_vec_q <= match_vec_d;
        if (match_vec_q == '0 && match_vec_d != '0) first_q <= cnt_q;
        acc_q <= in_valid;
        if (in_valid) begin
          for (int j = 4; j < WIN_BYTES; j++) win_q[j] <= win_q[j-4];
          win_q[0]    <= data_in[7:0];
          win_q[1]    <= data_in[15:8];
          win_q[2]    <= data_in[23:16];
          win_q[3]    <= data_in[31:24];
          fill_q      <= (fill_q == FILL_W'(WIN_BYTES)) ? fill_q : fill_q + FILL_W'(4);
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          out_valid_q <= (fill_q == FILL_W'(WIN_BYTES));
          data_out_q  <= {win_q[WIN_BYTES-1], win_q[WIN_BYTES-2],
                          win_q[WIN_BYTES-3], win_q[WIN_BYTES-4]};
        end
      end
      if (prog_we && (int'(prog_sel) < NUM_PATTERNS) && (int'(prog_idx) < MAX_LEN))
        pat_q[prog_sel][prog_idx] <= prog_data;
      if (prog_len_we && (int'(prog_sel) < NUM_PATTERNS))
        len_q[prog_sel] <= prog_data;
    end
  end

  assign match_vec       = match_vec_q;
  assign match_any       = |match_vec_q;
  assign first_match_off = first_q;
  assign out_valid       = out_valid_q;
  assign data_out        = data_out_q;

endmodule

// File: tb/tb_multi_string_comparator.sv
// Bench for multi_string_comparator: directed scenarios plus random traffic against a stream-history model.
module tb_multi_string_comparator;

  localparam int NP = 4;
  localparam int ML = 17;
  localparam int CW = 16;
  localparam int WW = (ML + 6) / 4;
  localparam int SW = 2;
  localparam int IW = 5;
`ifdef MULTI_STRING_CASE_FOLD_EN
  localparam logic FOLD = 1'b1;
`else
  localparam logic FOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, prog_we, prog_len_we;
  logic [31:0]   data_in;
  logic [SW-1:0] prog_sel;
  logic [IW-1:0] prog_idx;
  logic [7:0]    prog_data;
  logic [NP-1:0] match_vec;
  logic          match_any, out_valid;
  logic [SW-1:0] match_id;
  logic [CW-1:0] first_match_off;
  logic [31:0]   data_out;

  multi_string_comparator #(.NUM_PATTERNS(NP), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .prog_we(prog_we), .prog_len_we(prog_len_we), .prog_sel(prog_sel),
    .prog_idx(prog_idx), .prog_data(prog_data), .match_vec(match_vec),
    .match_any(match_any), .match_id(match_id), .first_match_off(first_match_off),
    .out_valid(out_valid), .data_out(data_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: patterns, recent stream words since clear, expected outputs
  logic [7:0]    m_pat [NP][ML];
  int            m_len [NP];
  logic [31:0]   m_words[$];
  int            m_cnt, m_first;
  logic [NP-1:0] m_mv;
  logic          m_ov, m_acc;
  logic [31:0]   m_dout;
  logic [31:0]   exp_q[$];

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (FOLD && b >= "A" && b <= "Z") return b + 8'd32;
    return b;
  endfunction

  // r = 0 is the most recently received byte
  function automatic logic [7:0] hist_byte(input int r);
    logic [31:0] w;
    w = m_words[m_words.size() - 1 - r / 4];
    return w[8 * (r % 4) +: 8];
  endfunction

  // Does the received stream end (0..3 bytes before its tail) with pattern p?
  function automatic logic [NP-1:0] model_hits();
    logic [NP-1:0] h;
    int n, l;
    logic ok;
    h = '0;
    n = 4 * m_words.size();
    for (int p = 0; p < NP; p++) begin
      l = (m_len[p] > ML) ? ML : m_len[p];
      for (int a = 0; a < 4; a++) begin
        if (l > 0 && a + l <= n) begin
          ok = 1'b1;
          for (int i = 0; i < l; i++)
            if (fold(m_pat[p][i]) != fold(hist_byte(a + l - 1 - i))) ok = 1'b0;
          if (ok) h[p] = 1'b1;
        end
      end
    end
    return h;
  endfunction

  task automatic model_flush();
    m_words.delete();
    m_cnt = 0; m_first = 0; m_mv = '0; m_ov = 1'b0; m_acc = 1'b0; m_dout = '0;
    exp_q.delete();
  endtask

  task automatic model_reset_all();
    model_flush();
    for (int p = 0; p < NP; p++) begin
      m_len[p] = 0;
      for (int i = 0; i < ML; i++) m_pat[p][i] = '0;
    end
  endtask

  task automatic model_step();
    logic [NP-1:0] h;
    if (clear) begin
      model_flush();
    end else begin
      if (m_acc) begin
        h = model_hits();
        if (m_mv == '0 && h != '0) m_first = m_cnt;
        m_mv = m_mv | h;
      end
      m_acc = in_valid;
      if (in_valid) begin
        m_dout = (m_words.size() == WW) ? m_words[0] : 32'h0;
        m_ov   = (m_words.size() == WW);
        m_words.push_back(data_in);
        if (m_words.size() > WW) void'(m_words.pop_front());
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_ov) exp_q.push_back(m_dout);
      end
    end
    if (prog_we && int'(prog_sel) < NP && int'(prog_idx) < ML) m_pat[prog_sel][prog_idx] = prog_data;
    if (prog_len_we && int'(prog_sel) < NP) m_len[prog_sel] = int'(prog_data);
  endtask

  function automatic int lowest(input logic [NP-1:0] v);
    for (int p = 0; p < NP; p++) if (v[p]) return p;
    return 0;
  endfunction

  task automatic compare_all();
    check("match_vec", 32'(match_vec), 32'(m_mv));
    check("match_any", 32'(match_any), 32'(|m_mv));
    check("match_id", 32'(match_id), 32'(lowest(m_mv)));
    check("first_off", 32'(first_match_off), 32'(m_first));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("data_out", data_out, m_dout);
  endtask

  // one clock: DUT and model both take the driven inputs, outputs checked on the falling edge
  task automatic tick();
    logic acc_now;
    @(posedge clk);
    acc_now = in_valid && !clear;
    model_step();
    @(negedge clk);
    compare_all();
    if (acc_now && out_valid) begin
      if (exp_q.size() == 0) check("fwd_empty", 32'(out_valid), 32'h0);
      else check("fwd_word", data_out, exp_q.pop_front());
    end
    clear = 1'b0; in_valid = 1'b0; prog_we = 1'b0; prog_len_we = 1'b0;
  endtask

  // driver tasks
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1; data_in = w; tick();
  endtask

  task automatic idle();
    tick();
  endtask

  task automatic do_clear(input logic iv, input logic [31:0] w);
    clear = 1'b1; in_valid = iv; data_in = w; tick();
  endtask

  task automatic prog_char(input int sel, input int idx, input logic [7:0] ch);
    prog_we = 1'b1; prog_sel = SW'(sel); prog_idx = IW'(idx); prog_data = ch; tick();
  endtask

  task automatic prog_len(input int sel, input int l);
    prog_len_we = 1'b1; prog_sel = SW'(sel); prog_data = 8'(l); tick();
  endtask

  task automatic prog_str(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) prog_char(sel, i, s[i]);
    prog_len(sel, s.len());
  endtask

  function automatic logic [7:0] alpha();
    case ($urandom_range(0, 9))
      0, 1, 2: return 8'h41;
      3, 4:    return 8'h42;
      5, 6:    return 8'h61;
      7, 8:    return 8'h62;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; data_in = '0;
    prog_we = 1'b0; prog_len_we = 1'b0; prog_sel = '0; prog_idx = '0; prog_data = '0;
    model_reset_all();
    repeat (2) @(negedge clk);
    check("rst_mv", 32'(match_vec), 32'h0);
    check("rst_off", 32'(first_match_off), 32'h0);
    check("rst_ov", 32'(out_valid), 32'h0);
    check("rst_dout", data_out, 32'h0);
    rst = 1'b0;

    // single-word hit
    prog_str(0, "EVIL");
    send(32'h4556494C);
    idle();
    check("evil_mv", 32'(match_vec), 32'h1);
    check("evil_id", 32'(match_id), 32'h0);
    check("evil_off", 32'(first_match_off), 32'h1);

    // match straddling two words
    do_clear(1'b0, 32'h0);
    prog_str(1, "ABCDEF");
    send(32'h58584142);
    send(32'h43444546);
    idle();
    check("xword_mv1", 32'(match_vec[1]), 32'h1);
    check("xword_off", 32'(first_match_off), 32'h2);

    // full-length all-zero pattern needs a filled window
    do_clear(1'b0, 32'h0);
    prog_len(2, 17);
    repeat (4) send(32'h0);
    idle();
    check("fill16_nohit", 32'(match_vec[2]), 32'h0);
    send(32'h0);
    idle();
    check("fill20_hit", 32'(match_vec[2]), 32'h1);

    // two slots hit on one word, then clear drops the incoming word
    do_clear(1'b0, 32'h0);
    prog_str(3, "CDEF");
    send(32'h58584142);
    send(32'h43444546);
    idle();
    check("dual_mv", 32'(match_vec), 32'hA);
    check("dual_id", 32'(match_id), 32'h1);
    do_clear(1'b1, 32'h4556494C);
    check("clr_mv", 32'(match_vec), 32'h0);
    check("clr_ov", 32'(out_valid), 32'h0);
    idle();
    check("clr_dropped", 32'(match_vec), 32'h0);

    // gaps in in_valid, then first forwarded word
    do_clear(1'b0, 32'h0);
    send(32'h11111111); idle(); send(32'h22222222); idle();
    do_clear(1'b0, 32'h0);
    for (int k = 1; k <= 5; k++) send(32'hA5000000 + 32'(k));
    check("fwd_not_yet", 32'(out_valid), 32'h0);
    send(32'hA5000006);
    check("fwd_first_ov", 32'(out_valid), 32'h1);
    check("fwd_first_word", data_out, 32'hA5000001);

    // case folding
    do_clear(1'b0, 32'h0);
    prog_str(0, "evil");
    send(32'h4576496C);
    idle();
    check("fold_hit", 32'(match_vec[0]), 32'(FOLD));

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) clear = 1'b1;
      if (r >= 3 && r < 20) begin
        prog_we     = $urandom_range(0, 1) == 1;
        prog_len_we = $urandom_range(0, 1) == 1;
        prog_sel    = SW'($urandom_range(0, NP - 1));
        prog_idx    = IW'($urandom_range(0, 19));
        if (prog_len_we && !prog_we)
          prog_data = ($urandom_range(0, 9) == 0) ? 8'd40 : 8'($urandom_range(0, 5));
        else
          prog_data = alpha();
      end
      in_valid = $urandom_range(0, 3) != 0;
      data_in  = {alpha(), alpha(), alpha(), alpha()};
      tick();
    end

    // asynchronous reset mid-stream wipes flags and patterns
    do_clear(1'b0, 32'h0);
    prog_str(0, "EVIL");
    send(32'h4556494C);
    idle();
    check("pre_rst_mv0", 32'(match_vec[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mv", 32'(match_vec), 32'h0);
    check("async_rst_any", 32'(match_any), 32'h0);
    model_reset_all();
    @(negedge clk);
    rst = 1'b0;
    send(32'h4556494C);
    idle();
    check("post_rst_nopat", 32'(match_vec), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
